ws2812_tx: RTL and testbench

Downstream consumer of the pixel FIFO. Pops 24-bit GRB pixel words from the FIFO's show-ahead read port and serialises them MSB-first onto a single WS2812 data line using cycle-counted high/low pulse widths. After NUM_LEDS pixels it holds the line low for the latch/reset period, then returns to idle. It sits between the pixel FIFO and the LED strip output pin.

---
 rtl/ws2812_tx_pkg.sv | 18 +
 rtl/ws2812_tx.sv | 161 ++++++++++++++++
 tb/tb_ws2812_tx.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ws2812_tx_pkg.sv
// Shared definitions for the WS2812 serialiser: FSM state encoding and
// default pulse timing for a 50 MHz clock.
package ws2812_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_LATCH = 2'd2
    } state_t;

    localparam int unsigned DEF_PIXEL_WIDTH  = 24;
    localparam int unsigned DEF_NUM_LEDS     = 64;
    localparam int unsigned DEF_BIT_CYCLES   = 62;     // 1.25 us
    localparam int unsigned DEF_T0H_CYCLES   = 20;
    localparam int unsigned DEF_T1H_CYCLES   = 40;
    localparam int unsigned DEF_RESET_CYCLES = 15000;  // 300 us latch

endpackage

// File: rtl/ws2812_tx.sv
// WS2812 serialiser: pops GRB pixel words from a show-ahead FIFO and drives
// them MSB-first onto one data line with cycle-counted pulse widths, then
// holds the line low for the latch period after each frame.
// Ports:
//   i_clk, i_reset     clock, asynchronous active-high reset
//   i_empty, i_data    FIFO empty flag and head word
//   o_rd               FIFO pop strobe (combinational, same cycle as sample)
//   o_dout             serial data line (registered)
//   o_busy             high whenever not idle
//   o_frame_done       pulse on the last latch cycle of a complete frame
//   o_underrun         pulse when the FIFO ran dry mid-frame
module ws2812_tx
    import ws2812_tx_pkg::*;
#(
    parameter int unsigned PIXEL_WIDTH  = DEF_PIXEL_WIDTH,
    parameter int unsigned NUM_LEDS     = DEF_NUM_LEDS,
    parameter int unsigned BIT_CYCLES   = DEF_BIT_CYCLES,
    parameter int unsigned T0H_CYCLES   = DEF_T0H_CYCLES,
    parameter int unsigned T1H_CYCLES   = DEF_T1H_CYCLES,
    parameter int unsigned RESET_CYCLES = DEF_RESET_CYCLES
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_empty,
    input  logic [PIXEL_WIDTH-1:0] i_data,
    output logic                   o_rd,
    output logic                   o_dout,
    output logic                   o_busy,
    output logic                   o_frame_done,
    output logic                   o_underrun
);

    localparam int unsigned PH_W  = $clog2(BIT_CYCLES);
    localparam int unsigned BIT_W = $clog2(PIXEL_WIDTH);
    localparam int unsigned PIX_W = $clog2(NUM_LEDS + 1);
    localparam int unsigned LAT_W = $clog2(RESET_CYCLES + 1);

    state_t                 state_q, state_d;
    logic [PH_W-1:0]        phase_q, phase_d;
    logic [BIT_W-1:0]       bit_q, bit_d;
    logic [PIX_W-1:0]       pix_q, pix_d;
    logic [LAT_W-1:0]       lat_q, lat_d;
    logic [PIXEL_WIDTH-1:0] shreg_q, shreg_d;
    logic                   frame_ok_q, frame_ok_d;
    logic                   dout_d, busy_d, done_d, underrun_d;
    logic                   rd_c;

    // State and datapath registers; outputs are registered from next-state
    // values so they line up with the state they describe.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q      <= ST_IDLE;
            phase_q      <= '0;
            bit_q        <= '0;
            pix_q        <= '0;
            lat_q        <= '0;
            shreg_q      <= '0;
            frame_ok_q   <= 1'b0;
            o_dout       <= 1'b0;
            o_busy       <= 1'b0;
            o_frame_done <= 1'b0;
            o_underrun   <= 1'b0;
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            bit_q        <= bit_d;
            pix_q        <= pix_d;
            lat_q        <= lat_d;
            shreg_q      <= shreg_d;
            frame_ok_q   <= frame_ok_d;
            o_dout       <= dout_d;
            o_busy       <= busy_d;
            o_frame_done <= done_d;
            o_underrun   <= underrun_d;
        end
    end

    // Next-state, counter and output decode.
    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        bit_d      = bit_q;
        pix_d      = pix_q;
        lat_d      = lat_q;
        shreg_d    = shreg_q;
        frame_ok_d = frame_ok_q;
        rd_c       = 1'b0;
        underrun_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!i_empty) begin
                    rd_c       = 1'b1;
                    shreg_d    = i_data;
                    bit_d      = BIT_W'(PIXEL_WIDTH - 1);
                    phase_d    = '0;
                    pix_d      = '0;
                    frame_ok_d = 1'b1;
                    state_d    = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (phase_q == PH_W'(BIT_CYCLES - 1)) begin
                    phase_d = '0;
                    if (bit_q != '0) begin
                        shreg_d = shreg_q << 1;
                        bit_d   = bit_q - BIT_W'(1);
                    end else if (pix_q == PIX_W'(NUM_LEDS - 1)) begin
                        lat_d   = '0;
                        state_d = ST_LATCH;
                    end else if (!i_empty) begin
                        // Fetch in the last cycle of the pixel: no gap on the line.
                        rd_c    = 1'b1;
                        shreg_d = i_data;
                        bit_d   = BIT_W'(PIXEL_WIDTH - 1);
                        pix_d   = pix_q + PIX_W'(1);
                    end else begin
                        underrun_d = 1'b1;
                        frame_ok_d = 1'b0;
                        lat_d      = '0;
                        state_d    = ST_LATCH;
                    end
                end else begin
                    phase_d = phase_q + PH_W'(1);
                end
            end
            ST_LATCH: begin
                if (lat_q == LAT_W'(RESET_CYCLES - 1)) begin
                    lat_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    lat_d = lat_q + LAT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // High portion of a bit depends on the MSB being sent next cycle.
        dout_d = (state_d == ST_SHIFT) &&
                 (phase_d < (shreg_d[PIXEL_WIDTH-1] ? PH_W'(T1H_CYCLES) : PH_W'(T0H_CYCLES)));
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_LATCH) && (lat_d == LAT_W'(RESET_CYCLES - 1)) && frame_ok_d;
    end

    // Never pop while reset is held.
    assign o_rd = rd_c & ~i_reset;

`ifdef FORMAL
    always_comb begin
        if (!i_reset) begin
            assert (!(o_rd && i_empty));
            assert ((state_q == ST_SHIFT) || !o_dout);
            assert (pix_q < PIX_W'(NUM_LEDS));
            cover (o_frame_done);
        end
    end
`endif

endmodule

// File: tb/tb_ws2812_tx.sv
// Bench for ws2812_tx: two instances (one and two LEDs per frame) fed from
// queue-based FIFO models, checked cycle by cycle against an expected
// waveform computed from the pulse-width rules.
module tb_ws2812_tx;

    localparam int unsigned BITC  = 10;
    localparam int unsigned PIXC  = 24 * BITC;
    localparam int unsigned LATC  = 20;

    logic        clk;
    logic        rst;
    logic        empty_a, empty_b;
    logic [23:0] data_a, data_b;
    logic        rd_a, dout_a, busy_a, done_a, und_a;
    logic        rd_b, dout_b, busy_b, done_b, und_b;

    logic [23:0] q_a[$];
    logic [23:0] q_b[$];
    bit          pend_a, pend_b;

    int n_checks;
    int n_fail;

    ws2812_tx #(.PIXEL_WIDTH(24), .NUM_LEDS(1), .BIT_CYCLES(BITC), .T0H_CYCLES(3),
                .T1H_CYCLES(7), .RESET_CYCLES(LATC)) dut_a (
        .i_clk(clk), .i_reset(rst), .i_empty(empty_a), .i_data(data_a),
        .o_rd(rd_a), .o_dout(dout_a), .o_busy(busy_a),
        .o_frame_done(done_a), .o_underrun(und_a)
    );

    ws2812_tx #(.PIXEL_WIDTH(24), .NUM_LEDS(2), .BIT_CYCLES(BITC), .T0H_CYCLES(3),
                .T1H_CYCLES(7), .RESET_CYCLES(LATC)) dut_b (
        .i_clk(clk), .i_reset(rst), .i_empty(empty_b), .i_data(data_b),
        .o_rd(rd_b), .o_dout(dout_b), .o_busy(busy_b),
        .o_frame_done(done_b), .o_underrun(und_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pop strobes are taken mid-cycle, when they are stable.
    always @(negedge clk) begin
        pend_a = rd_a;
        pend_b = rd_b;
    end

    // Show-ahead FIFO models: apply pops and present the new head just after the edge.
    always @(posedge clk) begin
        #1;
        if (pend_a && q_a.size() > 0) q_a.delete(0);
        if (pend_b && q_b.size() > 0) q_b.delete(0);
        pend_a = 1'b0;
        pend_b = 1'b0;
        empty_a = (q_a.size() == 0);
        empty_b = (q_b.size() == 0);
        data_a  = empty_a ? 24'h0 : q_a[0];
        data_b  = empty_b ? 24'h0 : q_b[0];
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Expected {rd,dout,busy,done,und} over one frame. Cycle 0 is the fetch
    // cycle in IDLE; avail is how many pixels the FIFO holds at that point.
    task automatic check_frame(input int sel, input logic [23:0] p0, input logic [23:0] p1,
                               input int avail, input bit started, input string tag);
        int          nl, k, last, off, p, b, ph;
        bit          got;
        logic [23:0] pix;
        logic        bitv;
        logic [4:0]  e, o;
        nl   = sel ? 2 : 1;
        k    = (avail < nl) ? avail : nl;
        last = k * PIXC + LATC + 1;
        if (!started) begin
            got = 1'b0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if ((sel ? rd_b : rd_a) === 1'b1) begin
                    got = 1'b1;
                    break;
                end
            end
            n_checks++;
            if (!got) begin
                n_fail++;
                $display("FAIL %s start: no o_rd within 20 cycles (got 0, need 1)", tag);
                return;
            end
        end
        for (int c = 0; c <= last; c++) begin
            if (c > 0) @(negedge clk);
            e[4] = (c == 0) || (c > 0 && c < k * PIXC && (c % PIXC) == 0) ||
                   (c == last && avail > k);
            if (c >= 1 && c <= k * PIXC) begin
                off  = c - 1;
                p    = off / PIXC;
                b    = (off % PIXC) / BITC;
                ph   = off % BITC;
                pix  = (p == 0) ? p0 : p1;
                bitv = pix[23 - b];
                e[3] = (ph < (bitv ? 7 : 3));
            end else begin
                e[3] = 1'b0;
            end
            e[2] = (c > 0) && (c < last);
            e[1] = (k == nl) && (c == k * PIXC + LATC);
            e[0] = (k < nl) && (c == k * PIXC + 1);
            o = sel ? {rd_b, dout_b, busy_b, done_b, und_b}
                    : {rd_a, dout_a, busy_a, done_a, und_a};
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL %s c=%0d {rd,dout,busy,done,und} got %b need %b", tag, c, o, e);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({rd_a, dout_a, busy_a, done_a, und_a, rd_b, dout_b, busy_b, done_b, und_b} !== 10'b0) begin
            n_fail++;
            $display("FAIL reset_outputs got %b need 0", {rd_a, dout_a, busy_a, done_a, und_a,
                                                          rd_b, dout_b, busy_b, done_b, und_b});
        end
        rst = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            n_checks++;
            if ({rd_a, dout_a, busy_a, done_a, und_a, rd_b, dout_b, busy_b, done_b, und_b} !== 10'b0) begin
                n_fail++;
                $display("FAIL idle_empty c=%0d got %b need 0", i, {rd_a, dout_a, busy_a, done_a, und_a,
                                                                    rd_b, dout_b, busy_b, done_b, und_b});
            end
        end
    endtask

    task automatic test_one_pixel();
        q_a.push_back(24'h800001);
        check_frame(0, 24'h800001, 24'h0, 1, 1'b0, "one_pixel");
    endtask

    task automatic test_two_pixels();
        q_b.push_back(24'hFFFFFF);
        q_b.push_back(24'h000000);
        check_frame(1, 24'hFFFFFF, 24'h000000, 2, 1'b0, "two_pixels");
    endtask

    task automatic test_underrun();
        logic [23:0] r0, r1;
        q_b.push_back(24'hA5A5A5);
        check_frame(1, 24'hA5A5A5, 24'h0, 1, 1'b0, "underrun");
        r0 = 24'($urandom());
        r1 = 24'($urandom());
        q_b.push_back(r0);
        q_b.push_back(r1);
        check_frame(1, r0, r1, 2, 1'b0, "restart");
    endtask

    task automatic test_back_to_back();
        logic [23:0] r[4];
        for (int i = 0; i < 4; i++) begin
            r[i] = 24'($urandom());
            q_b.push_back(r[i]);
        end
        check_frame(1, r[0], r[1], 4, 1'b0, "b2b_frame0");
        check_frame(1, r[2], r[3], 2, 1'b1, "b2b_frame1");
        for (int i = 0; i < 3; i++) begin
            r[i] = 24'($urandom());
            q_a.push_back(r[i]);
        end
        check_frame(0, r[0], 24'h0, 3, 1'b0, "b2b_a0");
        check_frame(0, r[1], 24'h0, 2, 1'b1, "b2b_a1");
        check_frame(0, r[2], 24'h0, 1, 1'b1, "b2b_a2");
    endtask

    task automatic test_reset_mid_bit();
        logic [23:0] p, nxt;
        bit          got;
        p = 24'($urandom()) | 24'h800000;
        q_a.push_back(p);
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rd_a === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!got) begin
            n_fail++;
            $display("FAIL midbit_start: no o_rd within 20 cycles (got 0, need 1)");
            return;
        end
        repeat (6) @(negedge clk);
        n_checks++;
        if (dout_a !== 1'b1) begin
            n_fail++;
            $display("FAIL midbit_high got %b need 1", dout_a);
        end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({dout_a, busy_a, rd_a} !== 3'b000) begin
            n_fail++;
            $display("FAIL midbit_async_reset {dout,busy,rd} got %b need 000", {dout_a, busy_a, rd_a});
        end
        nxt = 24'($urandom());
        q_a.push_back(nxt);
        @(posedge clk);
        @(posedge clk);
        #3 rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (rd_a !== 1'b1) begin
            n_fail++;
            $display("FAIL midbit_refetch rd got %b need 1", rd_a);
        end
        check_frame(0, nxt, 24'h0, 1, 1'b1, "after_reset");
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        empty_a  = 1'b1;
        empty_b  = 1'b1;
        data_a   = 24'h0;
        data_b   = 24'h0;
        pend_a   = 1'b0;
        pend_b   = 1'b0;
        test_reset();
        test_one_pixel();
        test_two_pixels();
        test_underrun();
        test_back_to_back();
        test_reset_mid_bit();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
